if_prefetch_unit: RTL and testbench
===================================

// Module: if_prefetch_unit
// PURPOSE
//  Parametrised instruction-fetch front end for the five-stage pipeline.
//  - Owns the fetch PC and issues Wishbone classic reads.
//  - Buffers {pc, instr} pairs in a DEPTH-entry FIFO and hands them to ID over valid/ready.
//  - Redirects from MEM (branch/jump) flush the buffer and restart fetch at the new PC.
// PARAMETERS
//  ADDR_WIDTH  32             address width
//  DATA_WIDTH  32             bus/instruction width; PC step = DATA_WIDTH/8
//  RESET_PC    32'h8000_0000  first fetch address after reset
//  DEPTH       4              FIFO entries; power of 2, >= 2
// PORTS
//  clk            in   1           single clock; all logic on rising edge
//  reset          in   1           synchronous, active-high
//  redirect_i     in   1           flush and restart at redirect_pc_i
//  redirect_pc_i  in   ADDR_WIDTH  new fetch PC
//  out_valid_o    out  1           FIFO head valid
//  out_ready_i    in   1           ID accepts head (pop when valid&ready)
//  out_pc_o       out  ADDR_WIDTH  PC of head entry
//  out_instr_o    out  DATA_WIDTH  instruction of head entry
//  wb_cyc_o       out  1           Wishbone cycle
//  wb_stb_o       out  1           Wishbone strobe
//  wb_ack_i       in   1           Wishbone ack
//  wb_adr_o       out  ADDR_WIDTH  fetch address
//  wb_dat_o       out  DATA_WIDTH  constant 0
//  wb_dat_i       in   DATA_WIDTH  read data
//  wb_sel_o       out  DATA_WIDTH/8  constant all ones
//  wb_we_o        out  1           constant 0
// BEHAVIOUR
//  - Reset values:
//    - wb_cyc_o=0, wb_stb_o=0, wb_adr_o=RESET_PC, wb_dat_o=0, wb_we_o=0, wb_sel_o='1.
//    - out_valid_o=0, out_pc_o=0, out_instr_o=0.
//    - FIFO count=0; fetch_pc=RESET_PC; discard=0.
//  - FSM IDLE / BUSY:
//    - IDLE->BUSY when (count + 1 pending) <= DEPTH, i.e. a slot is free.
//      Drives cyc=stb=1, adr=fetch_pc.
//    - BUSY holds cyc/stb/adr stable until wb_ack_i.
//    - On ack with discard=0: push {adr, wb_dat_i}; fetch_pc += DATA_WIDTH/8.
//      If a slot remains after push/pop accounting, stay BUSY with the new adr (back-to-back).
//      Otherwise go IDLE with cyc=stb=0.
//  - Slot reservation: an in-flight read always owns a FIFO slot, so a push never overflows.
//  - Latency: ack in cycle N with FIFO empty -> out_valid_o=1 in cycle N+1. No combinational path
//    from wb_dat_i to out_*.
//  - First request: cyc/stb high in the first cycle after reset deasserts.
//  - Pop on out_valid_o & out_ready_i. Push and pop in the same cycle leave count unchanged.
//  - Redirect (priority over push and pop):
//    - FIFO flushed; out_valid_o=0 next cycle; fetch_pc <= redirect_pc_i.
//    - In IDLE, or BUSY with ack in the same cycle: the ack data is dropped; next cycle issues
//      adr=redirect_pc_i.
//    - In BUSY without ack: set discard=1 and hold cyc/stb and the old adr until ack. That ack's
//      data is dropped; clear discard; next cycle issues adr=redirect_pc_i.
//    - A second redirect while discard=1 overwrites fetch_pc (last redirect wins).
//  - wb_ack_i is ignored while wb_cyc_o=0.
//  - Reset mid-transaction drops cyc/stb at that edge. A late ack is ignored.
//  - PC arithmetic wraps modulo 2^ADDR_WIDTH. Pointers wrap modulo DEPTH, with an extra bit to
//    distinguish full from empty.
// CONFIGURATION
//  IF_PREFETCH_ERR_EN defined:
//    - Adds port wb_err_i (in, 1) and port out_fault_o (out, 1, reset 0).
//    - wb_err_i terminates the cycle like ack and pushes an entry with fault=1 and instr=0.
//    - The FSM then enters HALT: cyc=stb=0, no further requests until redirect_i
//      (or reset) -> IDLE.
//    - With discard=1 the err is dropped like an ack and HALT is not entered.
//  IF_PREFETCH_ERR_EN undefined:
//    - Neither port exists; there is no HALT state; bus errors are not observed.
// TESTING
//  1 Reset, slave acks every req after 1 wait, out_ready_i=1
//    -> out_pc_o 8000_0000, 8000_0004, 8000_0008 in order; instrs match memory.
//  2 out_ready_i=0, DEPTH=4 -> exactly 4 reads issued, then cyc=0.
//    Pop one -> exactly one new read at 8000_0010.
//  3 Redirect to 8000_0100 while BUSY on 8000_0008, ack 3 cycles later
//    -> 8000_0008 data dropped; next adr 8000_0100; out_valid_o=0 until that entry arrives.
//  4 Redirect to 8000_0200 in the same cycle as ack and pop
//    -> FIFO empty next cycle; next request adr 8000_0200; no stale entry emitted.
//  5 Assert reset while cyc=1, then ack arrives after reset release
//    -> ack ignored; first request adr 8000_0000.
//  6 (ERR_EN) err on 8000_0004 -> entry pc 8000_0004 with fault=1; no further stb.
//    Redirect to 8000_0000 -> fetch resumes.

Source files
------------

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues Wishbone classic
// reads and buffers {pc, instr} pairs in a DEPTH-entry FIFO toward ID.
// Redirects flush the buffer and restart fetch at a new PC.
//
// Optional feature macro: IF_PREFETCH_ERR_EN (adds wb_err_i / out_fault_o and
// a HALT state entered on a bus error).
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   redirect_i, redirect_pc_i    flush and restart fetch at redirect_pc_i
//   out_valid_o/out_ready_i      head handshake toward ID
//   out_pc_o, out_instr_o        head entry payload
//   out_fault_o                  head entry bus-error flag (ERR_EN only)
//   wb_cyc_o, wb_stb_o, wb_adr_o Wishbone classic read request
//   wb_ack_i, wb_dat_i           Wishbone read response
//   wb_err_i                     Wishbone error response (ERR_EN only)
//   wb_dat_o, wb_sel_o, wb_we_o  constant read-only bus controls
module if_prefetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
  parameter int unsigned           DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      redirect_i,
  input  logic [ADDR_WIDTH-1:0]     redirect_pc_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [ADDR_WIDTH-1:0]     out_pc_o,
  output logic [DATA_WIDTH-1:0]     out_instr_o,
`ifdef IF_PREFETCH_ERR_EN
  output logic                      out_fault_o,
  input  logic                      wb_err_i,
`endif
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  input  logic                      wb_ack_i,
  output logic [ADDR_WIDTH-1:0]     wb_adr_o,
  output logic [DATA_WIDTH-1:0]     wb_dat_o,
  input  logic [DATA_WIDTH-1:0]     wb_dat_i,
  output logic [DATA_WIDTH/8-1:0]   wb_sel_o,
  output logic                      wb_we_o
);

  localparam int unsigned STEP  = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

`ifdef IF_PREFETCH_ERR_EN
  typedef enum logic [1:0] {IDLE, BUSY, HALT} state_t;
`else
  typedef enum logic {IDLE, BUSY} state_t;
`endif

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];

  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W-1:0]      wr_ptr_next, rd_ptr_next, count_next;
  logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_next, adr_next;
  logic                  discard, discard_next;
  logic                  cyc_next, issue;
  logic                  term, push, pop;
  logic [DATA_WIDTH-1:0] push_instr;

  logic                  head_valid_next;
  logic [ADDR_WIDTH-1:0] head_pc_next;
  logic [DATA_WIDTH-1:0] head_instr_next;

`ifdef IF_PREFETCH_ERR_EN
  logic                  fault_mem [DEPTH];
  logic                  err_term;
  logic                  head_fault_next;
`endif

  assign wb_dat_o = '0;
  assign wb_sel_o = '1;
  assign wb_we_o  = 1'b0;

  // Bus termination and FIFO push/pop accounting; redirect overrides both.
  always_comb begin
`ifdef IF_PREFETCH_ERR_EN
    err_term   = wb_cyc_o & wb_err_i;
    term       = wb_cyc_o & (wb_ack_i | wb_err_i);
    push_instr = err_term ? '0 : wb_dat_i;
`else
    term       = wb_cyc_o & wb_ack_i;
    push_instr = wb_dat_i;
`endif
    push        = term & ~discard & ~redirect_i;
    pop         = out_valid_o & out_ready_i & ~redirect_i;
    wr_ptr_next = wr_ptr + PTR_W'(push);
    rd_ptr_next = redirect_i ? wr_ptr : rd_ptr + PTR_W'(pop);
    count_next  = wr_ptr_next - rd_ptr_next;
  end

  // Next-state and next-output logic for the fetch FSM.
  always_comb begin
    state_next    = state;
    discard_next  = discard;
    fetch_pc_next = fetch_pc;

    if (redirect_i) begin
      fetch_pc_next = redirect_pc_i;
    end else if (push) begin
      fetch_pc_next = fetch_pc + ADDR_WIDTH'(STEP);
    end

    case (state)
      IDLE: begin
        if (count_next < PTR_W'(DEPTH)) state_next = BUSY;
      end
      BUSY: begin
        if (term) begin
          discard_next = 1'b0;
`ifdef IF_PREFETCH_ERR_EN
          if (err_term & push) begin
            state_next = HALT;
          end else
`endif
          if (count_next >= PTR_W'(DEPTH)) begin
            state_next = IDLE;
          end
        end else if (redirect_i) begin
          // Old read still owns the bus; its data is thrown away on ack.
          discard_next = 1'b1;
        end
      end
`ifdef IF_PREFETCH_ERR_EN
      HALT: begin
        if (redirect_i) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase

    cyc_next = (state_next == BUSY);
    // A fresh request starts whenever we enter BUSY or chain after a termination.
    issue    = cyc_next & ((state != BUSY) | term);
    adr_next = issue ? fetch_pc_next : wb_adr_o;
  end

  // FSM state and bus-side registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_adr_o <= RESET_PC;
      fetch_pc <= RESET_PC;
      discard  <= 1'b0;
    end else begin
      state    <= state_next;
      wb_cyc_o <= cyc_next;
      wb_stb_o <= cyc_next;
      wb_adr_o <= adr_next;
      fetch_pc <= fetch_pc_next;
      discard  <= discard_next;
    end
  end

  // FIFO storage; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr[IDX_W-1:0]]    <= wb_adr_o;
      instr_mem[wr_ptr[IDX_W-1:0]] <= push_instr;
`ifdef IF_PREFETCH_ERR_EN
      fault_mem[wr_ptr[IDX_W-1:0]] <= err_term;
`endif
    end
  end

  // Next head entry: bypass the pushed data when it becomes the head.
  always_comb begin
    head_valid_next = (count_next != '0);
    head_pc_next    = out_pc_o;
    head_instr_next = out_instr_o;
`ifdef IF_PREFETCH_ERR_EN
    head_fault_next = out_fault_o;
`endif
    if (head_valid_next) begin
      if (rd_ptr_next == wr_ptr) begin
        head_pc_next    = wb_adr_o;
        head_instr_next = push_instr;
`ifdef IF_PREFETCH_ERR_EN
        head_fault_next = err_term;
`endif
      end else begin
        head_pc_next    = pc_mem[rd_ptr_next[IDX_W-1:0]];
        head_instr_next = instr_mem[rd_ptr_next[IDX_W-1:0]];
`ifdef IF_PREFETCH_ERR_EN
        head_fault_next = fault_mem[rd_ptr_next[IDX_W-1:0]];
`endif
      end
    end
  end

  // FIFO pointers and registered head outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      out_valid_o <= 1'b0;
      out_pc_o    <= '0;
      out_instr_o <= '0;
`ifdef IF_PREFETCH_ERR_EN
      out_fault_o <= 1'b0;
`endif
    end else begin
      wr_ptr      <= wr_ptr_next;
      rd_ptr      <= rd_ptr_next;
      out_valid_o <= head_valid_next;
      out_pc_o    <= head_pc_next;
      out_instr_o <= head_instr_next;
`ifdef IF_PREFETCH_ERR_EN
      out_fault_o <= head_fault_next;
`endif
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the fetch stream.
module tb_if_prefetch_unit;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          redirect_i = 1'b0;
  logic [AW-1:0] redirect_pc_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [AW-1:0] out_pc_o;
  logic [DW-1:0] out_instr_o;
  logic          wb_cyc_o, wb_stb_o;
  logic          wb_ack_i = 1'b0;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [DW-1:0] wb_dat_i = '0;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o;

  if_prefetch_unit #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RESET_PC), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_instr_o(out_instr_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: expected FIFO contents, next fetch PC, stale in-flight read flag.
  ent_t        q[$];
  logic [31:0] exp_pc;
  bit          drop;
  bit          prev_cyc, prev_term;
  logic [31:0] prev_adr;
  int          wait_left;

  // Stimulus controls.
  int          ready_mode = 0;   // 0 never, 1 always, 2 random
  int          ack_wait = 1;
  bit          rand_wait = 0, rand_redir = 0, spur_en = 0;
  int          trig_mode = 0;    // 1: redirect on request to trig_adr, 2: on ack+pop
  logic [31:0] trig_adr = '0, trig_pc = '0;
  bit          fired = 0;
  logic [31:0] special_adr = 32'h1;
  int          special_wait = 0;

  // Observations.
  logic [31:0] issued[$];
  logic [31:0] popped_pc[$];
  logic [31:0] popped_instr[$];
  int          step_no, first_req_step;
  bit          cur_cyc, cur_valid;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait budget expired at t=%0t", name, $time);
  endtask

  // One clock cycle: compare DUT with model, drive inputs, advance the model.
  task automatic step();
    bit          cyc, new_req, ack, term, pop, redir;
    logic [31:0] adr, rpc;
    ent_t        e;
    @(negedge clk);
    step_no++;
    cyc       = wb_cyc_o;
    adr       = wb_adr_o;
    cur_cyc   = cyc;
    cur_valid = out_valid_o;
    new_req   = cyc && (!prev_cyc || prev_term);

    chk("out_valid", 32'(out_valid_o), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_pc", out_pc_o, q[0].pc);
      chk("out_instr", out_instr_o, q[0].instr);
    end
    if (!prev_cyc || prev_term) chk("cyc_issue", 32'(cyc), 32'(q.size() < int'(DEPTH)));
    else                        chk("cyc_hold", 32'(cyc), 32'd1);
    chk("stb_eq_cyc", 32'(wb_stb_o), 32'(cyc));
    if (new_req)  chk("req_adr", adr, exp_pc);
    else if (cyc) chk("adr_stable", adr, prev_adr);
    chk("slot_reserve", 32'(q.size() + (cyc ? 1 : 0) <= int'(DEPTH)), 32'd1);
    chk("wb_we", 32'(wb_we_o), 32'd0);
    chk("wb_sel", 32'(wb_sel_o), 32'hF);
    chk("wb_dat_o", wb_dat_o, 32'd0);

    if (new_req) begin
      issued.push_back(adr);
      if (first_req_step == 0) first_req_step = step_no;
      if (adr == special_adr) wait_left = special_wait;
      else if (rand_wait)     wait_left = int'($urandom_range(3, 0));
      else                    wait_left = ack_wait;
    end

    out_ready_i = (ready_mode == 2) ? ($urandom_range(9, 0) < 7) : (ready_mode != 0);
    if (cyc) begin
      ack = (wait_left == 0);
      if (wait_left > 0) wait_left--;
    end else begin
      ack = spur_en && ($urandom_range(4, 0) == 0);
    end
    term     = cyc && ack;
    wb_ack_i = ack;
    wb_dat_i = term ? memf(adr) : $urandom();
    pop      = (q.size() != 0) && out_ready_i;

    redir = 1'b0;
    rpc   = $urandom() & 32'hFFFF_FFFC;
    if (trig_mode == 1 && new_req && adr == trig_adr) begin
      redir = 1'b1; rpc = trig_pc; trig_mode = 0; fired = 1'b1;
    end else if (trig_mode == 2 && term && pop) begin
      redir = 1'b1; rpc = trig_pc; trig_mode = 0; fired = 1'b1;
    end else if (rand_redir && $urandom_range(99, 0) < 3) begin
      redir = 1'b1;
      case ($urandom_range(2, 0))
        0:       rpc = 32'hFFFF_FFF8;
        1:       rpc = RESET_PC + ($urandom_range(63, 0) << 2);
        default: rpc = $urandom() & 32'hFFFF_FFFC;
      endcase
    end
    redirect_i    = redir;
    redirect_pc_i = rpc;

    if (pop && !redir) begin
      popped_pc.push_back(out_pc_o);
      popped_instr.push_back(out_instr_o);
    end

    if (redir) begin
      q.delete();
      exp_pc = rpc;
      drop   = cyc && !term;
    end else begin
      if (pop) void'(q.pop_front());
      if (term) begin
        if (drop) begin
          drop = 1'b0;
        end else begin
          e.pc    = adr;
          e.instr = memf(adr);
          q.push_back(e);
          exp_pc  = adr + 32'd4;
        end
      end
    end
    prev_cyc  = cyc;
    prev_term = term;
    prev_adr  = adr;
  endtask

  task automatic do_reset(input bit spur);
    @(negedge clk);
    reset       = 1'b1;
    redirect_i  = 1'b0;
    out_ready_i = 1'b0;
    wb_ack_i    = spur;
    wb_dat_i    = $urandom();
    repeat (2) @(negedge clk);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_adr", wb_adr_o, 32'h8000_0000);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_pc", out_pc_o, 32'd0);
    chk("rst_instr", out_instr_o, 32'd0);
    reset = 1'b0;   // ack may stay high through this cycle while cyc=0
    q.delete();
    exp_pc = RESET_PC; drop = 1'b0; prev_cyc = 1'b0; prev_term = 1'b0;
    prev_adr = RESET_PC; wait_left = 0;
    issued.delete(); popped_pc.delete(); popped_instr.delete();
    step_no = 0; first_req_step = 0; trig_mode = 0; fired = 1'b0;
  endtask

  task automatic until_pops(input int n, input int budget, input string name);
    int k = 0;
    while (popped_pc.size() < n && k < budget) begin step(); k++; end
    if (popped_pc.size() < n) timeout(name);
  endtask

  task automatic until_issued(input int n, input int budget, input string name);
    int k = 0;
    while (issued.size() < n && k < budget) begin step(); k++; end
    if (issued.size() < n) timeout(name);
  endtask

  task automatic until_fired(input int budget, input string name);
    int k = 0;
    while (!fired && k < budget) begin step(); k++; end
    if (!fired) timeout(name);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fi, fp;

    // In-order stream with one wait state per read.
    do_reset(1'b0);
    ready_mode = 1; ack_wait = 1;
    until_pops(3, 60, "t1_pops");
    chk("t1_first_req_step", 32'(first_req_step), 32'd1);
    if (issued.size() >= 1) chk("t1_adr0", issued[0], 32'h8000_0000);
    if (popped_pc.size() >= 3) begin
      chk("t1_pc0", popped_pc[0], 32'h8000_0000);
      chk("t1_pc1", popped_pc[1], 32'h8000_0004);
      chk("t1_pc2", popped_pc[2], 32'h8000_0008);
      chk("t1_in0", popped_instr[0], 32'h5EAD_BEEF);
      chk("t1_in1", popped_instr[1], 32'h5EAD_BEEB);
      chk("t1_in2", popped_instr[2], 32'h5EAD_BEE7);
    end

    // Back-pressure fills exactly DEPTH slots; one pop frees exactly one read.
    do_reset(1'b0);
    ready_mode = 0; ack_wait = 0;
    repeat (20) step();
    chk("t2_reads_full", 32'(issued.size()), 32'd4);
    chk("t2_cyc_idle", 32'(cur_cyc), 32'd0);
    ready_mode = 1; step(); ready_mode = 0;
    repeat (10) step();
    chk("t2_reads_after_pop", 32'(issued.size()), 32'd5);
    if (issued.size() >= 5) chk("t2_adr4", issued[4], 32'h8000_0010);

    // Redirect while a read is outstanding; its ack arrives 3 cycles later.
    do_reset(1'b0);
    ready_mode = 1; ack_wait = 1;
    special_adr = 32'h8000_0008; special_wait = 3;
    trig_mode = 1; trig_adr = 32'h8000_0008; trig_pc = 32'h8000_0100;
    until_fired(40, "t3_fire");
    fi = issued.size(); fp = popped_pc.size();
    until_issued(fi + 1, 20, "t3_issue");
    if (issued.size() > fi) chk("t3_new_adr", issued[fi], 32'h8000_0100);
    until_pops(fp + 1, 20, "t3_pop");
    if (popped_pc.size() > fp) begin
      chk("t3_pc", popped_pc[fp], 32'h8000_0100);
      chk("t3_instr", popped_instr[fp], 32'h5EAD_BFEF);
    end
    special_adr = 32'h1;

    // Redirect coinciding with ack and pop.
    do_reset(1'b0);
    ready_mode = 1; ack_wait = 0;
    trig_mode = 2; trig_pc = 32'h8000_0200;
    until_fired(40, "t4_fire");
    step();
    chk("t4_valid_flushed", 32'(cur_valid), 32'd0);
    if (issued.size() > 0) chk("t4_new_adr", issued[issued.size()-1], 32'h8000_0200);
    fp = popped_pc.size();
    until_pops(fp + 1, 20, "t4_pop");
    if (popped_pc.size() > fp) begin
      chk("t4_pc", popped_pc[fp], 32'h8000_0200);
      chk("t4_instr", popped_instr[fp], 32'h5EAD_BCEF);
    end

    // Reset mid-transaction with a late ack around the release.
    do_reset(1'b0);
    ready_mode = 1; ack_wait = 10;
    repeat (3) step();
    chk("t5_busy_before_reset", 32'(cur_cyc), 32'd1);
    do_reset(1'b1);
    ack_wait = 1;
    until_pops(1, 20, "t5_pop");
    if (issued.size() >= 1) chk("t5_adr0", issued[0], 32'h8000_0000);
    if (popped_pc.size() >= 1) begin
      chk("t5_pc0", popped_pc[0], 32'h8000_0000);
      chk("t5_in0", popped_instr[0], 32'h5EAD_BEEF);
    end

    // PC wraps at the top of the address space.
    do_reset(1'b0);
    ready_mode = 1; ack_wait = 0;
    trig_mode = 1; trig_adr = RESET_PC; trig_pc = 32'hFFFF_FFF8;
    until_fired(5, "t7_fire");
    fi = issued.size();
    until_issued(fi + 3, 20, "t7_issue");
    if (issued.size() >= fi + 3) begin
      chk("t7_adr_fff8", issued[fi], 32'hFFFF_FFF8);
      chk("t7_adr_fffc", issued[fi+1], 32'hFFFF_FFFC);
      chk("t7_adr_wrap", issued[fi+2], 32'h0000_0000);
    end

    // Randomized traffic with a reset in the middle.
    do_reset(1'b0);
    ready_mode = 2; rand_wait = 1; rand_redir = 1; spur_en = 1;
    repeat (1500) step();
    do_reset(1'b1);
    repeat (1500) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
